// File: rtl/audio_tone_env_gen_pkg.sv
// Shared audio constants: PWM bit resolution, envelope state encodings and default widths.
// The PWM output stage uses the same BITRES so that frame boundaries line up.
package audio_tone_env_gen_pkg;

    localparam int BITRES       = 4;
    localparam int PERIOD_W_DEF = 16;
    localparam int SUST_W_DEF   = 8;
    localparam int DECAY_W_DEF  = 4;

    typedef enum logic [1:0] {
        ENV_IDLE    = 2'd0,
        ENV_SUSTAIN = 2'd1,
        ENV_DECAY   = 2'd2
    } env_state_t;

    // Square-wave gating of the envelope amplitude.
    function automatic logic [BITRES-1:0] tone_gate(input logic phase, input logic [BITRES-1:0] amp);
        return phase ? amp : {BITRES{1'b0}};
    endfunction

endpackage

// File: rtl/audio_tone_divider.sv
// Square-wave phase generator: phase toggles every `period` enabled clocks.
// A period of zero holds the phase high (DC tone).
module audio_tone_divider
    import audio_tone_env_gen_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    output logic                phase
);

    localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
    localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] half_cnt_r;
    logic                phase_r;
    logic                last_s;

    // >= rather than == keeps the counter bounded whatever the period value.
    assign last_s = (half_cnt_r >= (period - CNT_ONE));

    // Half-period counter and phase flip-flop; restart always begins a fresh high half.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            half_cnt_r <= CNT_ZERO;
            phase_r    <= 1'b0;
        end else if (restart) begin
            half_cnt_r <= CNT_ZERO;
            phase_r    <= 1'b1;
        end else if (en) begin
            if (period == CNT_ZERO) begin
                half_cnt_r <= CNT_ZERO;
                phase_r    <= 1'b1;
            end else if (last_s) begin
                half_cnt_r <= CNT_ZERO;
                phase_r    <= ~phase_r;
            end else begin
                half_cnt_r <= half_cnt_r + CNT_ONE;
            end
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/audio_tone_env_gen.sv
// Sound-effect voice: square-wave tone with a sustain + linear-decay envelope.
// pulsewidth is reloaded only on PWM frame wraps so no PWM frame is ever torn.
module audio_tone_env_gen
    import audio_tone_env_gen_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int SUST_W   = SUST_W_DEF,
    parameter int DECAY_W  = DECAY_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] tone_period,
    input  logic [BITRES-1:0]   volume,
    input  logic [SUST_W-1:0]   sustain,
    input  logic [DECAY_W-1:0]  decay_rate,
    output logic [BITRES-1:0]   pulsewidth,
    output logic                busy,
    output logic                frame_tick
);

    localparam logic [BITRES-1:0]  FRAME_ONE = {{(BITRES-1){1'b0}}, 1'b1};
    localparam logic [BITRES-1:0]  FRAME_MAX = {BITRES{1'b1}};
    localparam logic [BITRES-1:0]  FRAME_PRE = FRAME_MAX - FRAME_ONE;
    localparam logic [BITRES-1:0]  AMP_ZERO  = {BITRES{1'b0}};
    localparam logic [BITRES-1:0]  AMP_ONE   = {{(BITRES-1){1'b0}}, 1'b1};
    localparam logic [SUST_W-1:0]  SUST_ONE  = {{(SUST_W-1){1'b0}}, 1'b1};
    localparam logic [DECAY_W-1:0] DIV_ZERO  = {DECAY_W{1'b0}};
    localparam logic [DECAY_W-1:0] DIV_ONE   = {{(DECAY_W-1){1'b0}}, 1'b1};

    logic [BITRES-1:0]   frame_cnt_r;
    logic                frame_tick_r;
    env_state_t          state_r, state_s;
    logic [BITRES-1:0]   amp_r, amp_s;
    logic [SUST_W-1:0]   sust_cnt_r, sust_cnt_s;
    logic [DECAY_W-1:0]  div_cnt_r, div_cnt_s;
    logic [DECAY_W-1:0]  decay_r, decay_s;
    logic [PERIOD_W-1:0] period_r, period_s;
    logic [BITRES-1:0]   pulsewidth_r;
    logic                busy_r;
    logic                phase_s;

    audio_tone_divider #(
        .PERIOD_W (PERIOD_W)
    ) u_divider (
        .clk     (clk),
        .resetn  (resetn),
        .en      (busy_r),
        .restart (start),
        .period  (period_r),
        .phase   (phase_s)
    );

    // Envelope next-state: start beats stop, and both beat the frame-tick step.
    always_comb begin
        state_s    = state_r;
        amp_s      = amp_r;
        sust_cnt_s = sust_cnt_r;
        div_cnt_s  = div_cnt_r;
        decay_s    = decay_r;
        period_s   = period_r;
        if (start) begin
            state_s    = ENV_SUSTAIN;
            amp_s      = volume;
            sust_cnt_s = sustain;
            decay_s    = decay_rate;
            period_s   = tone_period;
        end else if (stop) begin
            state_s = ENV_IDLE;
            amp_s   = AMP_ZERO;
        end else if (frame_tick_r) begin
            case (state_r)
                ENV_SUSTAIN: begin
                    // sustain of 0 or 1 both leave at the first tick
                    if (sust_cnt_r <= SUST_ONE) begin
                        state_s   = ENV_DECAY;
                        div_cnt_s = decay_r;
                    end else begin
                        sust_cnt_s = sust_cnt_r - SUST_ONE;
                    end
                end
                ENV_DECAY: begin
                    if (div_cnt_r != DIV_ZERO) begin
                        div_cnt_s = div_cnt_r - DIV_ONE;
                    end else if (amp_r <= AMP_ONE) begin
                        state_s = ENV_IDLE;
                        amp_s   = AMP_ZERO;
                    end else begin
                        amp_s     = amp_r - AMP_ONE;
                        div_cnt_s = decay_r;
                    end
                end
                ENV_IDLE: begin
                    amp_s = AMP_ZERO;
                end
                default: begin
                    state_s = ENV_IDLE;
                    amp_s   = AMP_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame counter, envelope registers and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_r  <= {BITRES{1'b0}};
            frame_tick_r <= 1'b0;
            state_r      <= ENV_IDLE;
            amp_r        <= AMP_ZERO;
            sust_cnt_r   <= {SUST_W{1'b0}};
            div_cnt_r    <= DIV_ZERO;
            decay_r      <= DIV_ZERO;
            period_r     <= {PERIOD_W{1'b0}};
            pulsewidth_r <= AMP_ZERO;
            busy_r       <= 1'b0;
        end else begin
            frame_cnt_r  <= frame_cnt_r + FRAME_ONE;
            frame_tick_r <= (frame_cnt_r == FRAME_PRE);
            state_r      <= state_s;
            amp_r        <= amp_s;
            sust_cnt_r   <= sust_cnt_s;
            div_cnt_r    <= div_cnt_s;
            decay_r      <= decay_s;
            period_r     <= period_s;
            busy_r       <= (state_s != ENV_IDLE);
            // frame_tick_r is high exactly on the max->0 wrap edge; sample pre-edge amp/phase
            if (frame_tick_r) begin
                pulsewidth_r <= tone_gate(phase_s, amp_r);
            end
        end
    end

    assign pulsewidth = pulsewidth_r;
    assign busy       = busy_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_audio_tone_env_gen.sv
// Self-checking bench for audio_tone_env_gen: directed scenarios plus randomized notes,
// compared every cycle against a closed-form note model (amplitude from elapsed frames).
module tb_audio_tone_env_gen;
    import audio_tone_env_gen_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] tone_period = 16'd0;
    logic [3:0]  volume = 4'd0;
    logic [7:0]  sustain = 8'd0;
    logic [3:0]  decay_rate = 4'd0;
    logic [3:0]  pulsewidth;
    logic        busy;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail = 0;

    // Model state: frame position, held output, and note age in frames (k) and clocks (c)
    int m_fc = 0;
    int m_pw = 0;
    int m_note = 0;
    int m_k = 0;
    int m_c = 0;
    int m_per = 0;
    int m_vol = 0;
    int m_sus = 0;
    int m_dr = 0;

    audio_tone_env_gen dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .tone_period (tone_period),
        .volume      (volume),
        .sustain     (sustain),
        .decay_rate  (decay_rate),
        .pulsewidth  (pulsewidth),
        .busy        (busy),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sus_frames();
        return (m_sus < 1) ? 1 : m_sus;
    endfunction

    function automatic int m_busy();
        int v1;
        v1 = (m_vol < 1) ? 1 : m_vol;
        return (m_note != 0 && m_k < sus_frames() + (m_dr + 1) * v1) ? 1 : 0;
    endfunction

    function automatic int m_amp();
        if (m_busy() == 0) return 0;
        if (m_k < sus_frames()) return m_vol;
        return m_vol - (m_k - sus_frames()) / (m_dr + 1);
    endfunction

    function automatic int m_phase();
        if (m_per == 0) return 1;
        return (((m_c / m_per) % 2) == 0) ? 1 : 0;
    endfunction

    task automatic compare_outputs(input string tag);
        check_eq({tag, ".pulsewidth"}, int'(pulsewidth), m_pw);
        check_eq({tag, ".busy"}, int'(busy), m_busy());
        check_eq({tag, ".frame_tick"}, int'(frame_tick), (m_fc == 15) ? 1 : 0);
    endtask

    // One clock: drive start/stop, advance the model across the edge, compare outputs.
    task automatic tick(input bit st, input bit sp, input string tag);
        int  pre_pw;
        bit  pre_wrap;
        start    = st;
        stop     = sp;
        pre_wrap = (m_fc == 15);
        pre_pw   = (m_busy() != 0 && m_phase() != 0) ? m_amp() : 0;
        @(posedge clk);
        #1;
        if (pre_wrap) m_pw = pre_pw;
        if (st) begin
            m_note = 1; m_k = 0; m_c = 0;
            m_per = int'(tone_period); m_vol = int'(volume);
            m_sus = int'(sustain); m_dr = int'(decay_rate);
        end else if (sp) begin
            m_note = 0;
        end else if (m_busy() != 0) begin
            m_c++;
            if (pre_wrap) m_k++;
        end
        m_fc = (m_fc + 1) % 16;
        start = 1'b0;
        stop  = 1'b0;
        compare_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, tag);
    endtask

    task automatic set_note(input int per, input int vol, input int sus, input int dr);
        tone_period = per[15:0];
        volume      = vol[3:0];
        sustain     = sus[7:0];
        decay_rate  = dr[3:0];
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_eq({tag, ".pulsewidth"}, int'(pulsewidth), 0);
        check_eq({tag, ".busy"}, int'(busy), 0);
        check_eq({tag, ".frame_tick"}, int'(frame_tick), 0);
        m_fc = 0; m_pw = 0; m_note = 0; m_k = 0; m_c = 0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        do_reset("reset_init");

        // 1: asynchronous reset while a note is sounding
        set_note(0, 12, 255, 0);
        tick(1'b1, 1'b0, "t1_start");
        run(40, "t1_note");
        check_eq("t1_pw_before_reset", int'(pulsewidth), 12);
        do_reset("t1_async_reset");

        // 2: DC tone, sustain then linear decay one step per frame
        set_note(0, 12, 2, 0);
        tick(1'b1, 1'b0, "t2_start");
        run(16 * 18, "t2_env");
        check_eq("t2_idle_after_decay", int'(busy), 0);

        // 3: tone half-period equals one frame -> alternating 8/0
        set_note(16, 8, 255, 0);
        tick(1'b1, 1'b0, "t3_start");
        run(16 * 8, "t3_tone");

        // 4: slow decay, four frames per amplitude step
        set_note(0, 10, 1, 3);
        tick(1'b1, 1'b0, "t4_start");
        run(16 * 46, "t4_decay");

        // 5: stop mid-sustain, then start and stop together
        set_note(5, 9, 50, 1);
        tick(1'b1, 1'b0, "t5_start");
        run(40, "t5_sustain");
        tick(1'b0, 1'b1, "t5_stop");
        run(40, "t5_stopped");
        tick(1'b1, 1'b1, "t5_start_stop");
        run(40, "t5_restarted");

        // 6: retrigger during decay, then a start landing on a frame_tick cycle
        set_note(0, 6, 0, 0);
        tick(1'b1, 1'b0, "t6_start");
        run(16 * 3, "t6_decay");
        set_note(0, 15, 3, 0);
        tick(1'b1, 1'b0, "t6_retrigger");
        run(16 * 2 + 3, "t6_after_retrigger");
        for (int i = 0; i < 16 && m_fc != 15; i++) tick(1'b0, 1'b0, "t6_align");
        set_note(3, 13, 2, 1);
        tick(1'b1, 1'b0, "t6_start_on_tick");
        run(16 * 40, "t6_after_tick_start");

        // Randomized notes; inputs change every cycle to exercise latching
        for (int i = 0; i < 6000; i++) begin
            set_note($urandom_range(0, 40), $urandom_range(0, 15),
                     $urandom_range(0, 6), $urandom_range(0, 3));
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 149) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
